// File: rtl/instruction_encoder_pkg.sv
// Field map shared by the instruction decoder and encoder, so both ends
// agree on where each field lives inside a 32-bit instruction word.
package instr_fields_pkg;

  localparam int OPCODE_W  = 5;
  localparam int REG_W     = 5;
  localparam int LIT_W     = 12;
  localparam int INSTR_W   = 32;
  localparam int DEC_LIT_W = 64;

  localparam int OP_LSB  = 27;
  localparam int RD_LSB  = 22;
  localparam int RS_LSB  = 17;
  localparam int RT_LSB  = 12;
  localparam int LIT_LSB = 0;

  typedef struct packed {
    logic [OPCODE_W-1:0] opcode;
    logic [REG_W-1:0]    rd;
    logic [REG_W-1:0]    rs;
    logic [REG_W-1:0]    rt;
    logic [LIT_W-1:0]    literal;
  } instr_fields_t;

  // Places each field at its fixed bit position; no opcode-specific rewriting.
  function automatic logic [INSTR_W-1:0] pack_instr(input instr_fields_t f);
    logic [INSTR_W-1:0] w;
    w = '0;
    w[OP_LSB  +: OPCODE_W] = f.opcode;
    w[RD_LSB  +: REG_W]    = f.rd;
    w[RS_LSB  +: REG_W]    = f.rs;
    w[RT_LSB  +: REG_W]    = f.rt;
    w[LIT_LSB +: LIT_W]    = f.literal;
    return w;
  endfunction

endpackage

// File: rtl/instruction_encoder_if.sv
// Field-input and memory-write handshake bundle of the instruction encoder.
// The master side drives decoded fields and consumes encoded words.
interface instruction_encoder_if #(
  parameter int ADDR_W = 16
);
  import instr_fields_pkg::*;

  logic                  in_valid;
  logic                  in_ready;
  logic [OPCODE_W-1:0]   opcode;
  logic [REG_W-1:0]      rd;
  logic [REG_W-1:0]      rs;
  logic [REG_W-1:0]      rt;
  logic [DEC_LIT_W-1:0]  literal;

  logic                  out_valid;
  logic                  out_ready;
  logic [INSTR_W-1:0]    out_word;
  logic [ADDR_W-1:0]     out_addr;

  modport master (
    output in_valid, opcode, rd, rs, rt, literal, out_ready,
    input  in_ready, out_valid, out_word, out_addr
  );

  modport slave (
    input  in_valid, opcode, rd, rs, rt, literal, out_ready,
    output in_ready, out_valid, out_word, out_addr
  );

endinterface

// File: rtl/instruction_encoder_fifo.sv
// Small first-word-fall-through FIFO for {word, address} entries.
// Pointers carry one extra wrap bit so full and empty stay distinguishable.
module encoder_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 48
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             wr_valid_i,
  output logic             wr_ready_o,
  input  logic [WIDTH-1:0] wr_data_i,
  output logic             rd_valid_o,
  input  logic             rd_ready_i,
  output logic [WIDTH-1:0] rd_data_o
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam int PTR_W = IDX_W + 1;

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             full;
  logic             empty;
  logic             push;
  logic             pop;

  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[PTR_W-1] != rd_ptr_q[PTR_W-1]) &&
                 (wr_ptr_q[IDX_W-1:0] == rd_ptr_q[IDX_W-1:0]);

  assign wr_ready_o = !full;
  assign rd_valid_o = !empty;
  assign rd_data_o  = mem_q[rd_ptr_q[IDX_W-1:0]];

  assign push = wr_valid_i && !full && !clear;
  assign pop  = !empty && rd_ready_i && !clear;

  // Pointer advance; a flush rewinds both pointers and wins over push/pop.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (clear) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
  end

  // Pointer registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Storage; zeroed on reset so the head reads as zero while in reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (push) begin
      mem_q[wr_ptr_q[IDX_W-1:0]] <= wr_data_i;
    end
  end

endmodule

// File: rtl/instruction_encoder.sv
// Packs decoded fields into 32-bit instruction words, rejects literals that
// do not fit in 12 bits, tags each word with a sequential program address
// and queues it toward the memory-write port.
module instruction_encoder
  import instr_fields_pkg::*;
#(
  parameter int                DEPTH     = 4,
  parameter int                ADDR_W    = 16,
  parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    clear,
  instruction_encoder_if.slave    bus,
  output logic                    err_overflow,
  output logic [7:0]              err_count
);

  localparam int ENTRY_W = INSTR_W + ADDR_W;

  instr_fields_t       fields;
  logic [INSTR_W-1:0]  word;
  logic                lit_ok;
  logic                in_ready;
  logic                fifo_ready;
  logic                accept;
  logic                push;
  logic [ENTRY_W-1:0]  head;

  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic                err_overflow_q, err_overflow_d;
  logic [7:0]          err_count_q, err_count_d;

  assign fields = '{opcode:  bus.opcode,
                    rd:      bus.rd,
                    rs:      bus.rs,
                    rt:      bus.rt,
                    literal: bus.literal[LIT_W-1:0]};
  assign word   = pack_instr(fields);
  assign lit_ok = ~|bus.literal[DEC_LIT_W-1:LIT_W];

  // Ready is held low during reset and flush and never looks at out_ready.
  assign in_ready    = rst_n && !clear && fifo_ready;
  assign bus.in_ready = in_ready;
  assign accept      = bus.in_valid && in_ready;
  assign push        = accept && lit_ok;

  encoder_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (ENTRY_W)
  ) u_fifo (
    .clk        (clk),
    .rst_n      (rst_n),
    .clear      (clear),
    .wr_valid_i (push),
    .wr_ready_o (fifo_ready),
    .wr_data_i  ({word, addr_q}),
    .rd_valid_o (bus.out_valid),
    .rd_ready_i (bus.out_ready),
    .rd_data_o  (head)
  );

  assign bus.out_word = head[ENTRY_W-1 -: INSTR_W];
  assign bus.out_addr = head[ADDR_W-1:0];

  assign err_overflow = err_overflow_q;
  assign err_count    = err_count_q;

  // Address advances only on a stored word; rejected sets bump the error state.
  always_comb begin
    addr_d         = addr_q;
    err_overflow_d = 1'b0;
    err_count_d    = err_count_q;
    if (clear) begin
      addr_d      = BASE_ADDR;
      err_count_d = '0;
    end else if (push) begin
      addr_d = addr_q + ADDR_W'(1);
    end else if (accept) begin
      err_overflow_d = 1'b1;
      if (err_count_q != 8'hFF) err_count_d = err_count_q + 8'd1;
    end
  end

  // Address counter and error registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_q         <= BASE_ADDR;
      err_overflow_q <= 1'b0;
      err_count_q    <= '0;
    end else begin
      addr_q         <= addr_d;
      err_overflow_q <= err_overflow_d;
      err_count_q    <= err_count_d;
    end
  end

endmodule

// File: tb/tb_instruction_encoder.sv
// Bench for instruction_encoder: two instances (16-bit and 2-bit address)
// share one stimulus stream and are checked every cycle against a queue model.
module tb_instruction_encoder;
  import instr_fields_pkg::*;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        clear = 1'b0;
  logic        inValid = 1'b0;
  logic        outReady = 1'b0;
  logic [4:0]  opF = '0, rdF = '0, rsF = '0, rtF = '0;
  logic [63:0] litF = '0;

  logic        errOv16, errOv2;
  logic [7:0]  errCnt16, errCnt2;

  int checks = 0;
  int errors = 0;

  instruction_encoder_if #(.ADDR_W(16)) bus16 ();
  instruction_encoder_if #(.ADDR_W(2))  bus2 ();

  assign bus16.in_valid  = inValid;
  assign bus16.opcode    = opF;
  assign bus16.rd        = rdF;
  assign bus16.rs        = rsF;
  assign bus16.rt        = rtF;
  assign bus16.literal   = litF;
  assign bus16.out_ready = outReady;
  assign bus2.in_valid   = inValid;
  assign bus2.opcode     = opF;
  assign bus2.rd         = rdF;
  assign bus2.rs         = rsF;
  assign bus2.rt         = rtF;
  assign bus2.literal    = litF;
  assign bus2.out_ready  = outReady;

  instruction_encoder #(.DEPTH(DEPTH), .ADDR_W(16), .BASE_ADDR(16'd0)) dut16 (
    .clk          (clk),
    .rst_n        (rst_n),
    .clear        (clear),
    .bus          (bus16),
    .err_overflow (errOv16),
    .err_count    (errCnt16)
  );

  instruction_encoder #(.DEPTH(DEPTH), .ADDR_W(2), .BASE_ADDR(2'd0)) dut2 (
    .clk          (clk),
    .rst_n        (rst_n),
    .clear        (clear),
    .bus          (bus2),
    .err_overflow (errOv2),
    .err_count    (errCnt2)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] word;
    int          addr;
  } entry_t;

  entry_t modelQ[$];
  int     modelAddr = 0;
  int     modelErrCnt = 0;
  bit     modelErrPulse = 1'b0;
  bit     modelTake;
  bit     modelInRange;
  int     popLog16[$];
  int     popLog2[$];

  logic [4:0]  setOp [3] = '{5'b01011, 5'b10101, 5'b11001};
  logic [4:0]  setRd [3] = '{5'b11010, 5'b11110, 5'b00010};
  logic [4:0]  setRs [3] = '{5'b10101, 5'b00110, 5'b00010};
  logic [4:0]  setRt [3] = '{5'b01010, 5'b00000, 5'b00000};
  logic [63:0] setLit[3] = '{64'h05F, 64'h175, 64'h006};

  // Word value as a weighted sum of the fields.
  function automatic logic [31:0] expectedWord(input logic [4:0] op, input logic [4:0] rd,
                                               input logic [4:0] rs, input logic [4:0] rt,
                                               input logic [63:0] lit);
    longint w;
    w = longint'(op) * 134217728 + longint'(rd) * 4194304 + longint'(rs) * 131072
      + longint'(rt) * 4096 + longint'(lit % 64'd4096);
    return w[31:0];
  endfunction

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", name, actual, expected, $time);
    end
  endtask

  // Reference model: an ordered queue of {word, address} plus error counters.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      modelQ.delete();
      modelAddr     = 0;
      modelErrCnt   = 0;
      modelErrPulse = 1'b0;
    end else if (clear) begin
      modelQ.delete();
      modelAddr     = 0;
      modelErrCnt   = 0;
      modelErrPulse = 1'b0;
    end else begin
      modelTake    = inValid && (modelQ.size() < DEPTH);
      modelInRange = (litF >> 12) == 64'd0;
      if (modelQ.size() != 0 && outReady) void'(modelQ.pop_front());
      modelErrPulse = modelTake && !modelInRange;
      if (modelTake && modelInRange) begin
        modelQ.push_back('{expectedWord(opF, rdF, rsF, rtF, litF), modelAddr});
        modelAddr = (modelAddr + 1) % 65536;
      end
      if (modelTake && !modelInRange && modelErrCnt < 255) modelErrCnt++;
    end
  end

  // Every cycle, compare both instances against the model on the falling edge.
  always @(negedge clk) begin
    if (!rst_n) begin
      checkOutput("rst_out_valid", bus16.out_valid, 0);
      checkOutput("rst_out_word", bus16.out_word, 0);
      checkOutput("rst_out_addr", bus16.out_addr, 0);
      checkOutput("rst_in_ready", bus16.in_ready, 0);
      checkOutput("rst_err_overflow", errOv16, 0);
      checkOutput("rst_err_count", errCnt16, 0);
      checkOutput("rst_out_valid2", bus2.out_valid, 0);
    end else begin
      checkOutput("in_ready", bus16.in_ready, !clear && (modelQ.size() < DEPTH));
      checkOutput("in_ready2", bus2.in_ready, !clear && (modelQ.size() < DEPTH));
      checkOutput("out_valid", bus16.out_valid, modelQ.size() != 0);
      checkOutput("out_valid2", bus2.out_valid, modelQ.size() != 0);
      if (modelQ.size() != 0) begin
        checkOutput("out_word", bus16.out_word, modelQ[0].word);
        checkOutput("out_addr", bus16.out_addr, modelQ[0].addr);
        checkOutput("out_word2", bus2.out_word, modelQ[0].word);
        checkOutput("out_addr2", bus2.out_addr, modelQ[0].addr % 4);
      end
      checkOutput("err_overflow", errOv16, modelErrPulse);
      checkOutput("err_count", errCnt16, modelErrCnt);
      checkOutput("err_overflow2", errOv2, modelErrPulse);
      checkOutput("err_count2", errCnt2, modelErrCnt);
      if (bus16.out_valid && outReady) popLog16.push_back(int'(bus16.out_addr));
      if (bus2.out_valid && outReady) popLog2.push_back(int'(bus2.out_addr));
    end
  end

  // Drive one cycle of inputs, then return just after the edge that used them.
  task automatic applyStimulus(input bit v, input logic [4:0] op, input logic [4:0] rd,
                               input logic [4:0] rs, input logic [4:0] rt,
                               input logic [63:0] lit, input bit rdy, input bit clr);
    inValid  = v;
    opF      = op;
    rdF      = rd;
    rsF      = rs;
    rtF      = rt;
    litF     = lit;
    outReady = rdy;
    clear    = clr;
    @(posedge clk);
    #2;
  endtask

  task automatic applySet(input int k, input bit rdy);
    applyStimulus(1'b1, setOp[k], setRd[k], setRs[k], setRt[k], setLit[k], rdy, 1'b0);
  endtask

  task automatic idle(input int n, input bit rdy);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, '0, '0, '0, '0, '0, rdy, 1'b0);
  endtask

  task automatic doClear();
    applyStimulus(1'b0, '0, '0, '0, '0, '0, 1'b0, 1'b1);
  endtask

  // Watchdog so the run always ends.
  initial begin
    #100000;
    $display("[TB] FAIL watchdog: got timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  // Directed scenario sequence.
  initial begin
    int exp16[5];
    int exp2[5];
    exp16 = '{0, 1, 2, 3, 4};
    exp2  = '{0, 1, 2, 3, 0};

    #1 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    checkOutput("reset_in_ready", bus16.in_ready, 0);
    checkOutput("reset_out_valid", bus16.out_valid, 0);
    rst_n = 1'b1;
    idle(1, 1'b1);

    $display("[TB] single set after reset");
    applySet(0, 1'b1);
    checkOutput("t1_valid", bus16.out_valid, 1);
    checkOutput("t1_word", bus16.out_word, 32'h5EAAA05F);
    checkOutput("t1_addr", bus16.out_addr, 0);
    idle(1, 1'b1);
    checkOutput("t1_drained", bus16.out_valid, 0);
    doClear();

    $display("[TB] back-to-back sets");
    applySet(0, 1'b1);
    checkOutput("t2_word0", bus16.out_word, 32'h5EAAA05F);
    checkOutput("t2_addr0", bus16.out_addr, 0);
    applySet(1, 1'b1);
    checkOutput("t2_word1", bus16.out_word, 32'hAF8C0175);
    checkOutput("t2_addr1", bus16.out_addr, 1);
    applySet(2, 1'b1);
    checkOutput("t2_word2", bus16.out_word, expectedWord(5'b11001, 5'b00010, 5'b00010, 5'b0, 64'd6));
    checkOutput("t2_addr2", bus16.out_addr, 2);
    idle(1, 1'b1);
    checkOutput("t2_drained", bus16.out_valid, 0);
    doClear();

    $display("[TB] fill, back-pressure, drain and address wrap");
    popLog16.delete();
    popLog2.delete();
    applySet(0, 1'b0);
    applySet(1, 1'b0);
    applySet(2, 1'b0);
    applySet(0, 1'b0);
    checkOutput("t3_full_ready", bus16.in_ready, 0);
    checkOutput("t3_head_word", bus16.out_word, 32'h5EAAA05F);
    applySet(1, 1'b0);
    applySet(1, 1'b0);
    checkOutput("t3_held_ready", bus16.in_ready, 0);
    checkOutput("t3_held_word", bus16.out_word, 32'h5EAAA05F);
    checkOutput("t3_held_addr", bus16.out_addr, 0);
    applySet(1, 1'b1);
    checkOutput("t3_ready_back", bus16.in_ready, 1);
    applySet(1, 1'b1);
    idle(6, 1'b1);
    checkOutput("t3_pop_count", popLog16.size(), 5);
    checkOutput("t3_pop_count2", popLog2.size(), 5);
    for (int i = 0; i < 5; i++) begin
      if (i < popLog16.size()) checkOutput("t3_pop_addr", popLog16[i], exp16[i]);
      if (i < popLog2.size())  checkOutput("t3_pop_addr2", popLog2[i], exp2[i]);
    end

    $display("[TB] clear with words queued and a set offered");
    applySet(0, 1'b0);
    applySet(1, 1'b0);
    checkOutput("t4_queued", bus16.out_valid, 1);
    applyStimulus(1'b1, setOp[2], setRd[2], setRs[2], setRt[2], setLit[2], 1'b0, 1'b1);
    checkOutput("t4_cleared", bus16.out_valid, 0);
    applySet(2, 1'b0);
    checkOutput("t4_valid", bus16.out_valid, 1);
    checkOutput("t4_base_addr", bus16.out_addr, 0);
    idle(2, 1'b1);

    $display("[TB] literal overflow");
    applyStimulus(1'b1, setOp[0], setRd[0], setRs[0], setRt[0], 64'h1000, 1'b1, 1'b0);
    checkOutput("t5_err_pulse", errOv16, 1);
    checkOutput("t5_err_count", errCnt16, 1);
    checkOutput("t5_no_word", bus16.out_valid, 0);
    idle(1, 1'b1);
    checkOutput("t5_err_pulse_end", errOv16, 0);
    applySet(1, 1'b1);
    checkOutput("t5_addr_kept", bus16.out_addr, 1);
    checkOutput("t5_word", bus16.out_word, 32'hAF8C0175);
    idle(1, 1'b1);

    $display("[TB] reset mid-drain");
    applySet(0, 1'b0);
    applySet(1, 1'b0);
    applySet(2, 1'b0);
    idle(1, 1'b1);
    #1 rst_n = 1'b0;
    #1;
    checkOutput("t6_async_valid", bus16.out_valid, 0);
    checkOutput("t6_async_ready", bus16.in_ready, 0);
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    checkOutput("t6_err_count", errCnt16, 0);
    applySet(0, 1'b1);
    checkOutput("t6_valid", bus16.out_valid, 1);
    checkOutput("t6_addr", bus16.out_addr, 0);
    idle(2, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
